// File: rtl/cpu_init_loader.sv
// cpu_init_loader: streams a 40-bit word source into the CPU's BTB, BHT and
// register file, holds the CPU in init for a few cycles, then releases it.
// Words are consumed in order: BTB entries, then BHT entries, then registers.
module cpu_init_loader #(
   parameter int BTB_DEPTH = 256,
   parameter int BHT_DEPTH = 256,
   parameter int REG_DEPTH = 32,
   parameter int HOLD_CYC  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        in_valid,
   input  logic [39:0] in_data,
   output logic        in_ready,
   output logic [7:0]  btb_addr,
   output logic [39:0] btb_init,
   output logic        btb_we,
   output logic [7:0]  bht_addr,
   output logic [1:0]  bht_init,
   output logic        bht_we,
   output logic [4:0]  reg_addr,
   output logic [31:0] reg_init,
   output logic        reg_we,
   output logic        rst_switch,
   output logic        start_switch,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      S_IDLE, S_BTB, S_BHT, S_REG, S_HOLD, S_RUN
   } state_t;

   // Terminal index values; the single index counter also times HOLD.
   localparam logic [8:0] BTB_LAST  = 9'(BTB_DEPTH - 1);
   localparam logic [8:0] BHT_LAST  = 9'(BHT_DEPTH - 1);
   localparam logic [8:0] REG_LAST  = 9'(REG_DEPTH - 1);
   localparam logic [8:0] HOLD_LAST = 9'(HOLD_CYC - 1);

   state_t      r_state, w_state_next;
   logic [8:0]  r_idx, w_idx_next;
   logic        w_accept;

   logic [7:0]  r_btb_addr;
   logic [39:0] r_btb_init;
   logic        r_btb_we;
   logic [7:0]  r_bht_addr;
   logic [1:0]  r_bht_init;
   logic        r_bht_we;
   logic [4:0]  r_reg_addr;
   logic [31:0] r_reg_init;
   logic        r_reg_we;

   // Next-state, index advance and state-decoded status outputs.
   always_comb begin
      w_state_next = r_state;
      w_idx_next   = r_idx;
      w_accept     = 1'b0;
      in_ready     = 1'b0;
      rst_switch   = 1'b0;
      start_switch = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (go) begin
               w_state_next = S_BTB;
               w_idx_next   = 9'd0;
            end
         end
         S_BTB: begin
            in_ready   = 1'b1;
            rst_switch = 1'b1;
            busy       = 1'b1;
            w_accept   = in_valid;
            if (in_valid) begin
               if (r_idx == BTB_LAST) begin
                  w_idx_next   = 9'd0;
                  w_state_next = S_BHT;
               end else begin
                  w_idx_next = r_idx + 9'd1;
               end
            end
         end
         S_BHT: begin
            in_ready   = 1'b1;
            rst_switch = 1'b1;
            busy       = 1'b1;
            w_accept   = in_valid;
            if (in_valid) begin
               if (r_idx == BHT_LAST) begin
                  w_idx_next   = 9'd0;
                  w_state_next = S_REG;
               end else begin
                  w_idx_next = r_idx + 9'd1;
               end
            end
         end
         S_REG: begin
            in_ready   = 1'b1;
            rst_switch = 1'b1;
            busy       = 1'b1;
            w_accept   = in_valid;
            if (in_valid) begin
               if (r_idx == REG_LAST) begin
                  w_idx_next   = 9'd0;
                  w_state_next = S_HOLD;
               end else begin
                  w_idx_next = r_idx + 9'd1;
               end
            end
         end
         S_HOLD: begin
            // The first HOLD cycle is the one carrying the final reg_we.
            rst_switch = 1'b1;
            busy       = 1'b1;
            if (r_idx == HOLD_LAST) begin
               w_idx_next   = 9'd0;
               w_state_next = S_RUN;
            end else begin
               w_idx_next = r_idx + 9'd1;
            end
         end
         S_RUN: begin
            start_switch = 1'b1;
            done         = 1'b1;
            if (go) begin
               w_state_next = S_BTB;
               w_idx_next   = 9'd0;
            end
         end
         default: begin
            w_state_next = S_IDLE;
            w_idx_next   = 9'd0;
         end
      endcase
   end

   // State and index register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= 9'd0;
      end else begin
         r_state <= w_state_next;
         r_idx   <= w_idx_next;
      end
   end

   // Write ports: one-cycle strobe after each accept; address/data hold otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_btb_addr <= '0;
         r_btb_init <= '0;
         r_btb_we   <= 1'b0;
         r_bht_addr <= '0;
         r_bht_init <= '0;
         r_bht_we   <= 1'b0;
         r_reg_addr <= '0;
         r_reg_init <= '0;
         r_reg_we   <= 1'b0;
      end else begin
         r_btb_we <= w_accept && (r_state == S_BTB);
         r_bht_we <= w_accept && (r_state == S_BHT);
         r_reg_we <= w_accept && (r_state == S_REG);
         if (w_accept && (r_state == S_BTB)) begin
            r_btb_addr <= r_idx[7:0];
            r_btb_init <= in_data;
         end
         if (w_accept && (r_state == S_BHT)) begin
            r_bht_addr <= r_idx[7:0];
            r_bht_init <= in_data[1:0];
         end
         if (w_accept && (r_state == S_REG)) begin
            r_reg_addr <= r_idx[4:0];
            r_reg_init <= in_data[31:0];
         end
      end
   end

   assign btb_addr = r_btb_addr;
   assign btb_init = r_btb_init;
   assign btb_we   = r_btb_we;
   assign bht_addr = r_bht_addr;
   assign bht_init = r_bht_init;
   assign bht_we   = r_bht_we;
   assign reg_addr = r_reg_addr;
   assign reg_init = r_reg_init;
   assign reg_we   = r_reg_we;

endmodule

// File: tb/tb_cpu_init_loader.sv
// Self-checking bench for cpu_init_loader: a reference model predicts the
// phase and pushes each accepted word onto a scoreboard; the write strobes
// seen on the following cycle pop and check it.
module tb_cpu_init_loader;

   localparam int BTB_D = 256;
   localparam int BHT_D = 256;
   localparam int REG_D = 32;
   localparam int HOLD  = 4;
   localparam int TOTAL = BTB_D + BHT_D + REG_D;

   logic        clk = 1'b0;
   logic        rst, go, in_valid;
   logic [39:0] in_data;
   logic        in_ready;
   logic [7:0]  btb_addr;
   logic [39:0] btb_init;
   logic        btb_we;
   logic [7:0]  bht_addr;
   logic [1:0]  bht_init;
   logic        bht_we;
   logic [4:0]  reg_addr;
   logic [31:0] reg_init;
   logic        reg_we;
   logic        rst_switch, start_switch, busy, done;

   cpu_init_loader #(
      .BTB_DEPTH(BTB_D), .BHT_DEPTH(BHT_D), .REG_DEPTH(REG_D), .HOLD_CYC(HOLD)
   ) dut (
      .clk(clk), .rst(rst), .go(go), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready),
      .btb_addr(btb_addr), .btb_init(btb_init), .btb_we(btb_we),
      .bht_addr(bht_addr), .bht_init(bht_init), .bht_we(bht_we),
      .reg_addr(reg_addr), .reg_init(reg_init), .reg_we(reg_we),
      .rst_switch(rst_switch), .start_switch(start_switch),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   typedef struct {
      int          kind;   // 1 BTB, 2 BHT, 3 REG
      int          addr;
      logic [39:0] data;
   } sb_item_t;

   sb_item_t sb_q[$];

   // Reference model state (updated on rising edges only)
   int m_phase = 0;   // 0 idle, 1 btb, 2 bht, 3 reg, 4 hold, 5 run
   int m_cnt = 0;
   int m_total = 0;
   int m_rst_cnt = 0;
   int cyc = 0;
   int last_acc_cyc = 0;

   function automatic int depth_of(input int ph);
      if (ph == 1) return BTB_D;
      if (ph == 2) return BHT_D;
      return REG_D;
   endfunction

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         m_phase = 0;
         m_cnt   = 0;
         m_rst_cnt++;
         sb_q.delete();
      end else begin
         case (m_phase)
            0, 5: if (go) begin
               m_phase = 1; m_cnt = 0; m_total = 0;
            end
            1, 2, 3: if (in_valid) begin
               sb_q.push_back('{m_phase, m_cnt, in_data});
               m_total++;
               last_acc_cyc = cyc;
               m_cnt++;
               if (m_cnt == depth_of(m_phase)) begin
                  m_cnt = 0;
                  m_phase++;
               end
            end
            4: begin
               m_cnt++;
               if (m_cnt == HOLD) begin
                  m_cnt = 0;
                  m_phase = 5;
               end
            end
            default: ;
         endcase
      end
   end

   // Checker state (updated on falling edges only)
   int          seen_rst = 0;
   logic [7:0]  sh_btb_addr = '0;
   logic [39:0] sh_btb_init = '0;
   logic [7:0]  sh_bht_addr = '0;
   logic [1:0]  sh_bht_init = '0;
   logic [4:0]  sh_reg_addr = '0;
   logic [31:0] sh_reg_init = '0;
   int          n_btb = 0, n_bht = 0, n_reg = 0;
   logic        prev_start = 1'b0;
   int          clr_req = 0, clr_seen = 0;

   always @(negedge clk) begin
      sb_item_t it;
      int kind;
      if (clr_req != clr_seen) begin
         clr_seen = clr_req;
         n_btb = 0; n_bht = 0; n_reg = 0;
      end
      if (m_rst_cnt != seen_rst) begin
         seen_rst = m_rst_cnt;
         sh_btb_addr = '0; sh_btb_init = '0;
         sh_bht_addr = '0; sh_bht_init = '0;
         sh_reg_addr = '0; sh_reg_init = '0;
      end
      check_eq("in_ready", in_ready, m_phase inside {1, 2, 3});
      check_eq("rst_switch", rst_switch, m_phase inside {1, 2, 3, 4});
      check_eq("busy", busy, m_phase inside {1, 2, 3, 4});
      check_eq("start_switch", start_switch, m_phase == 5);
      check_eq("done", done, m_phase == 5);
      kind = 0;
      if (sb_q.size() > 0) begin
         it = sb_q.pop_front();
         kind = it.kind;
         case (kind)
            1: begin sh_btb_addr = it.addr[7:0]; sh_btb_init = it.data; end
            2: begin sh_bht_addr = it.addr[7:0]; sh_bht_init = it.data[1:0]; end
            default: begin sh_reg_addr = it.addr[4:0]; sh_reg_init = it.data[31:0]; end
         endcase
      end
      check_eq("btb_we", btb_we, kind == 1);
      check_eq("bht_we", bht_we, kind == 2);
      check_eq("reg_we", reg_we, kind == 3);
      check_eq("btb_addr", btb_addr, sh_btb_addr);
      check_eq("btb_init", btb_init, sh_btb_init);
      check_eq("bht_addr", bht_addr, sh_bht_addr);
      check_eq("bht_init", bht_init, sh_bht_init);
      check_eq("reg_addr", reg_addr, sh_reg_addr);
      check_eq("reg_init", reg_init, sh_reg_init);
      if (btb_we === 1'b1) n_btb++;
      if (bht_we === 1'b1) n_bht++;
      if (reg_we === 1'b1) n_reg++;
      if (start_switch === 1'b1 && prev_start === 1'b0)
         check_eq("start_delay", 64'(cyc - last_acc_cyc), HOLD);
      prev_start = start_switch;
   end

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_data"}, {btb_addr, btb_init[15:0], bht_addr, bht_init, reg_addr, reg_init[23:0]},
               64'd0);
      check_eq({tag, "_hi"}, {btb_init[39:16], reg_init[31:24]}, 64'd0);
      check_eq({tag, "_flags"}, {in_ready, btb_we, bht_we, reg_we, rst_switch, start_switch, busy, done},
               64'd0);
   endtask

   // One load: pulse go, feed words until RUN; optional go/rst injection.
   task automatic run_load(input int duty, input bit cnt_data, input int go_bht_idx, input int rst_reg_idx);
      bit go_fired = 1'b0;
      bit rst_fired = 1'b0;
      bit finished = 1'b0;
      logic [63:0] rnd;
      @(posedge clk);
      clr_req++;
      @(negedge clk);
      go = 1'b1;
      in_valid = 1'b0;
      @(negedge clk);
      go = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         rnd = {$urandom, $urandom};
         in_valid = ($urandom_range(0, 99) < duty);
         in_data  = cnt_data ? 40'(m_total) : rnd[39:0];
         go  = 1'b0;
         rst = 1'b0;
         if (!go_fired && go_bht_idx >= 0 && m_phase == 2 && m_cnt == go_bht_idx) begin
            go = 1'b1; go_fired = 1'b1;
         end
         if (!rst_fired && rst_reg_idx >= 0 && m_phase == 3 && m_cnt == rst_reg_idx) begin
            rst = 1'b1; rst_fired = 1'b1;
         end
         @(negedge clk);
         if (rst_fired && rst) begin
            rst = 1'b0;
            check_all_zero("mid_rst");
            finished = 1'b1;
            break;
         end
         if (m_phase == 5) begin
            finished = 1'b1;
            break;
         end
      end
      go = 1'b0;
      in_valid = 1'b0;
      check_eq("load_timeout", finished, 1'b1);
      if (finished && !rst_fired) begin
         repeat (3) @(negedge clk);
         check_eq("btb_count", n_btb, BTB_D);
         check_eq("bht_count", n_bht, BHT_D);
         check_eq("reg_count", n_reg, REG_D);
         check_eq("total_count", n_btb + n_bht + n_reg, TOTAL);
         check_eq("done_level", done, 1'b1);
      end
   endtask

   initial begin
      rst = 1'b1; go = 1'b0; in_valid = 1'b0; in_data = '0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      // Full-rate load with in_data = word count (also crosses BTB->BHT with valid held)
      run_load(100, 1'b1, -1, -1);
      // In RUN: in_valid alone must not be accepted
      in_valid = 1'b1;
      repeat (5) @(negedge clk);
      in_valid = 1'b0;
      // go in RUN reloads; gappy input; stray go in BHT at index 100
      run_load(50, 1'b0, 100, -1);
      // Reset mid-REG at index 10, then a clean restart from IDLE
      run_load(50, 1'b0, -1, 10);
      repeat (4) @(negedge clk);
      check_all_zero("idle_after_rst");
      run_load(70, 1'b0, -1, -1);
      repeat (4) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
